// File: rtl/com_to_between.sv
// UART (8N1) receiver feeding a small FIFO, drained to a neighbour board over a 4-phase req/ack handshake.
// Define COM_TO_BETWEEN_CRC8_EN to enable the running CRC8 (poly 0x07) of delivered bytes; otherwise crc is 0x00.
`timescale 1ns/1ps

module com_to_between #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx,
    output logic [7:0]                  t_out,
    output logic                        tsent,
    input  logic                        trecieve,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        overrun,
    output logic [7:0]                  crc
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int CNTW = $clog2(CLKS_PER_BIT);

    localparam logic [CNTW-1:0] BIT_LAST  = CNTW'(CLKS_PER_BIT - 1);
    localparam logic [CNTW-1:0] HALF_LAST = CNTW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]   FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rxState_t;
    typedef enum logic [1:0] {H_IDLE, H_REQ, H_REL} hsState_t;

    rxState_t        rxState;
    hsState_t        hsState;
    logic            rxMeta, rxSync;
    logic            ackMeta, ackSync;
    logic [CNTW-1:0] bitCnt;
    logic [2:0]      bitIdx;
    logic [7:0]      rxShift;
    logic            pushReq;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wrPtr, rdPtr;
    logic            full, empty, pop, doPush;

    // rx idles high, so its synchronizer resets to 1 to avoid a false start bit after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxMeta  <= 1'b1;
            rxSync  <= 1'b1;
            ackMeta <= 1'b0;
            ackSync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep the two flops a true shift chain.
            rxMeta  <= rx;
            rxSync  <= rxMeta;
            ackMeta <= trecieve;
            ackSync <= ackMeta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rxState   <= R_IDLE;
            bitCnt    <= '0;
            bitIdx    <= '0;
            rxShift   <= '0;
            pushReq   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            pushReq   <= 1'b0;
            frame_err <= 1'b0;
            case (rxState)
                R_IDLE: begin
                    bitCnt <= '0;
                    if (!rxSync) rxState <= R_START;
                end
                R_START: begin
                    if (bitCnt == HALF_LAST) begin
                        bitCnt  <= '0;
                        bitIdx  <= '0;
                        rxState <= rxSync ? R_IDLE : R_DATA;
                    end else begin
                        bitCnt <= bitCnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (bitCnt == BIT_LAST) begin
                        bitCnt  <= '0;
                        rxShift <= {rxSync, rxShift[7:1]};
                        if (bitIdx == 3'd7) rxState <= R_STOP;
                        else                bitIdx  <= bitIdx + 1'b1;
                    end else begin
                        bitCnt <= bitCnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (bitCnt == BIT_LAST) begin
                        bitCnt <= '0;
                        if (rxSync) begin
                            pushReq <= 1'b1;
                            rxState <= R_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            rxState   <= R_BREAK;
                        end
                    end else begin
                        bitCnt <= bitCnt + 1'b1;
                    end
                end
                R_BREAK: begin
                    if (rxSync) rxState <= R_IDLE;
                end
                default: rxState <= R_IDLE;
            endcase
        end
    end

    assign full   = (fifo_count == FULL_CNT);
    assign empty  = (fifo_count == '0);
    assign pop    = (hsState == H_REQ) && tsent && ackSync;
    assign doPush = pushReq && (!full || pop);

    // NOTE: the storage array has no reset; fifo_count guarantees a stale entry is never read.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= rxShift;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (pop)    rdPtr <= rdPtr + 1'b1;
            if (doPush && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !doPush) fifo_count <= fifo_count - 1'b1;
            if (pushReq && full && !pop) overrun <= 1'b1;
        end
    end

    // t_out is latched from the head one cycle before tsent rises and held until the next load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsState <= H_IDLE;
            t_out   <= 8'h00;
            tsent   <= 1'b0;
        end else begin
            case (hsState)
                H_IDLE: begin
                    if (!empty && !ackSync) begin
                        t_out   <= mem[rdPtr];
                        hsState <= H_REQ;
                    end
                end
                H_REQ: begin
                    if (!tsent) begin
                        tsent <= 1'b1;
                    end else if (ackSync) begin
                        tsent   <= 1'b0;
                        hsState <= H_REL;
                    end
                end
                H_REL: begin
                    if (!ackSync) hsState <= H_IDLE;
                end
                default: hsState <= H_IDLE;
            endcase
        end
    end

`ifdef COM_TO_BETWEEN_CRC8_EN
    function automatic logic [7:0] crc8Next(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        return x;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   crc <= 8'h00;
        else if (pop) crc <= crc8Next(crc, t_out);
    end
`else
    assign crc = 8'h00;
`endif

endmodule

// File: tb/tb_com_to_between.sv
// Directed bench for com_to_between: UART frames in, neighbour handshake modelled with a 2-cycle ack delay.
`timescale 1ns/1ps

module tb_com_to_between;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

`ifdef COM_TO_BETWEEN_CRC8_EN
    localparam logic [7:0] CHECK_CRC = 8'hF4;
`else
    localparam logic [7:0] CHECK_CRC = 8'h00;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   rx;
    logic                   trecieve;
    logic [7:0]             t_out;
    logic                   tsent;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   frame_err;
    logic                   overrun;
    logic [7:0]             crc;

    com_to_between #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .t_out      (t_out),
        .tsent      (tsent),
        .trecieve   (trecieve),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .crc        (crc)
    );

    always #5 clk = ~clk;

    int         nVec = 0;
    int         nMis = 0;
    logic [7:0] got [$];
    int         riseCount = 0;
    int         ferrCount = 0;
    int         setupErr  = 0;
    logic       tsentPrev = 1'b0;
    logic [7:0] toutPrev  = 8'h00;
    logic       ackEn     = 1'b0;
    logic [1:0] ackPipe   = 2'b00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        if (obs !== exp) begin
            nMis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Neighbour board: acknowledge follows tsent two cycles late when enabled.
    initial trecieve = 1'b0;
    always @(negedge clk) begin
        ackPipe  = {ackPipe[0], ackEn & tsent};
        trecieve = ackPipe[1];
    end

    // Record every delivered byte at the rising edge of tsent and watch t_out setup.
    always @(negedge clk) begin
        if (tsent && !tsentPrev) begin
            got.push_back(t_out);
            riseCount++;
            if (t_out !== toutPrev) setupErr++;
        end
        if (frame_err) ferrCount++;
        tsentPrev = tsent;
        toutPrev  = t_out;
    end

    function automatic logic [15:0] gotAt(input int i);
        return (got.size() > i) ? {8'h00, got[i]} : 16'hDEAD;
    endfunction

    task automatic sendBit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic stopBit, input int holdLow);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(d[i]);
        sendBit(stopBit);
        if (holdLow > 0) begin
            rx = 1'b0;
            repeat (holdLow) @(negedge clk);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic waitGot(input int n, input int budget);
        for (int i = 0; i < budget && got.size() < n; i++) @(negedge clk);
        check("deliver_count", got.size(), n);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_t_out",      t_out,      8'h00);
        check("rst_tsent",      tsent,      1'b0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_frame_err",  frame_err,  1'b0);
        check("rst_overrun",    overrun,    1'b0);
        check("rst_crc",        crc,        8'h00);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame through the full handshake.
        ackEn = 1'b1;
        base  = got.size();
        sendFrame(8'hA5, 1'b1, 0);
        waitGot(base + 1, 100);
        repeat (20) @(negedge clk);
        check("a5_data",       gotAt(base), 8'hA5);
        check("a5_rises",      riseCount,   1);
        check("a5_fifo_count", fifo_count,  0);
        check("a5_tsent_low",  tsent,       1'b0);
        check("a5_no_ferr",    ferrCount,   0);

        // Short low glitch is rejected at the start-bit midpoint.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_fifo_count", fifo_count, 0);
        check("glitch_no_ferr",    ferrCount,  0);
        check("glitch_no_rise",    riseCount,  1);
        base = got.size();
        sendFrame(8'h5A, 1'b1, 0);
        waitGot(base + 1, 100);
        check("after_glitch_data", gotAt(base), 8'h5A);

        // Bad stop bit followed by a held-low line, then a good frame.
        sendFrame(8'h3C, 1'b0, 40);
        repeat (20) @(negedge clk);
        check("ferr_pulses",     ferrCount,  1);
        check("ferr_fifo_count", fifo_count, 0);
        check("ferr_no_rise",    riseCount,  2);
        base = got.size();
        sendFrame(8'h11, 1'b1, 0);
        waitGot(base + 1, 100);
        check("after_ferr_data", gotAt(base), 8'h11);

        // Stalled neighbour: five bytes into a four-entry buffer.
        ackEn = 1'b0;
        repeat (6) @(negedge clk);
        base = got.size();
        for (int d = 1; d <= 5; d++) sendFrame(8'(d), 1'b1, 0);
        repeat (10) @(negedge clk);
        check("full_fifo_count", fifo_count, DEPTH);
        check("full_overrun",    overrun,    1'b1);
        check("full_tsent",      tsent,      1'b1);
        check("full_t_out",      t_out,      8'h01);
        ackEn = 1'b1;
        waitGot(base + 4, 200);
        repeat (30) @(negedge clk);
        for (int i = 0; i < 4; i++) check("drain_order", gotAt(base + i), 16'(i + 1));
        check("drain_total",       got.size(),  base + 4);
        check("drain_fifo_count",  fifo_count,  0);
        check("overrun_sticky",    overrun,     1'b1);

        // Reset in the middle of data bit 4.
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'b1);
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midbyte_t_out",      t_out,      8'h00);
        check("midbyte_tsent",      tsent,      1'b0);
        check("midbyte_fifo_count", fifo_count, 0);
        check("midbyte_overrun",    overrun,    1'b0);
        check("midbyte_frame_err",  frame_err,  1'b0);
        check("midbyte_crc",        crc,        8'h00);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Reset while waiting in H_REQ.
        ackEn = 1'b0;
        repeat (4) @(negedge clk);
        sendFrame(8'h42, 1'b1, 0);
        for (int i = 0; i < 60 && !tsent; i++) @(negedge clk);
        check("hreq_tsent", tsent, 1'b1);
        check("hreq_t_out", t_out, 8'h42);
        #2 reset = 1'b0;
        #1;
        check("hreq_rst_tsent",      tsent,      1'b0);
        check("hreq_rst_t_out",      t_out,      8'h00);
        check("hreq_rst_fifo_count", fifo_count, 0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        ackEn = 1'b1;
        repeat (4) @(negedge clk);
        base = got.size();
        sendFrame(8'h7E, 1'b1, 0);
        waitGot(base + 1, 100);
        repeat (30) @(negedge clk);
        check("post_rst_data",       gotAt(base), 8'h7E);
        check("post_rst_total",      got.size(),  base + 1);
        check("post_rst_fifo_count", fifo_count,  0);

        // CRC check string "123456789".
        pulseReset();
        check("crc_cleared", crc, 8'h00);
        base = got.size();
        for (int d = 8'h31; d <= 8'h39; d++) sendFrame(8'(d), 1'b1, 0);
        waitGot(base + 9, 200);
        repeat (30) @(negedge clk);
        for (int i = 0; i < 9; i++) check("crc_stream", gotAt(base + i), 16'(8'h31 + i));
        check("crc_value",   crc,      CHECK_CRC);
        check("tout_setup",  setupErr, 0);
        check("ferr_total",  ferrCount, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/com_to_between.md
COM_TO_BETWEEN -- requirements
Module: com_to_between

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per UART bit; even, >= 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: receive buffer entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rx  input  1  UART serial in, 8N1, LSB first, idle high; asynchronous.
REQ-006 SHALL have port t_out  output  8  parallel byte to neighbour board.
REQ-007 SHALL have port tsent  output  1  request: t_out valid.
REQ-008 SHALL have port trecieve  input  1  acknowledge from neighbour; asynchronous.
REQ-009 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes buffered.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-011 SHALL have port overrun  output  1  sticky: byte dropped on full buffer.
REQ-012 SHALL have port crc  output  8  running CRC8 of delivered bytes.

Function
REQ-013 SHALL pass rx and trecieve through 2-flop synchronizers (rx flops reset to 1, trecieve to 0); logic uses only synchronized copies.
REQ-014 SHALL run receiver FSM IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: synchronized rx = 0 -> START, counter cleared.
REQ-016 START: at CLKS_PER_BIT/2 cycles resample; 0 -> DATA, 1 -> IDLE (glitch, no byte, no error).
REQ-017 DATA: sample every CLKS_PER_BIT cycles, shift LSB first; after 8th bit -> STOP.
REQ-018 STOP: sample after CLKS_PER_BIT; 1 -> push byte, -> IDLE; 0 -> pulse frame_err one cycle, discard byte, -> BREAK.
REQ-019 BREAK: stay until synchronized rx = 1, then IDLE.
REQ-020 Push SHALL occur the cycle after stop sample; fifo_count updates same edge.
REQ-021 Push when full and no pop same cycle: byte dropped, overrun set to 1, held until reset.
REQ-022 Push and pop in same cycle SHALL both succeed (including when full); fifo_count unchanged.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-024 SHALL run 4-phase handshake FSM H_IDLE, H_REQ, H_REL.
REQ-025 H_IDLE: buffer non-empty and synced trecieve = 0 -> drive t_out = head, next cycle assert tsent, -> H_REQ.
REQ-026 H_REQ: synced trecieve = 1 -> deassert tsent, pop head, -> H_REL.
REQ-027 H_REL: synced trecieve = 0 -> H_IDLE; t_out SHALL hold the delivered byte through H_REQ and H_REL.
REQ-028 t_out SHALL be set up one cycle before tsent rises.
REQ-029 Receiver and handshake FSMs SHALL be independent; a full buffer never stalls rx sampling.

Reset
REQ-030 reset low SHALL asynchronously force: both FSMs to idle, counters and pointers 0, fifo_count 0, t_out 0x00, tsent 0, frame_err 0, overrun 0, crc 0x00.
REQ-031 Reset mid-byte or mid-handshake SHALL discard partial byte and buffer; after release, first byte needs a fresh start bit.
REQ-032 Release SHALL be synchronous to clk (first active edge follows deassertion).

Configuration
REQ-033 Macro COM_TO_BETWEEN_CRC8_EN defined: crc updated at each pop, polynomial 0x07, init 0x00, MSB-first over the popped byte, in one cycle.
REQ-034 Macro undefined: crc tied to 0x00, no CRC logic synthesized; other behaviour identical.

Verification
REQ-035 Frame 0xA5 at CLKS_PER_BIT=16, trecieve tied to tsent with 2-cycle delay -> t_out=0xA5, tsent rises once, fifo_count returns to 0.
REQ-036 rx low pulse of 4 cycles -> no push, no frame_err, FSM back in IDLE.
REQ-037 Frame 0x3C with stop bit 0, then rx held low 40 cycles -> one frame_err pulse, no push, next valid 0x11 delivered correctly.
REQ-038 trecieve held 0, send 5 bytes 0x01..0x05 with FIFO_DEPTH=4 -> fifo_count=4, overrun=1; releasing handshake delivers 0x01..0x04 in order.
REQ-039 Assert reset during DATA bit 4 and during H_REQ -> all outputs to reset values immediately; subsequent 0x7E received cleanly.
REQ-040 With COM_TO_BETWEEN_CRC8_EN, deliver 0x31..0x39 ("123456789") -> crc=0xF4; without macro crc stays 0x00.
